cla_pipe_adder: RTL

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla_block.sv | 30 +++
 rtl/cla_pipe_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

    // Default number of bits handled by one lookahead block
    localparam int CLA_BLOCK = 4;

    // Propagate/generate pair for one lookahead block
    typedef struct packed {
        logic [CLA_BLOCK-1:0] p;
        logic [CLA_BLOCK-1:0] g;
    } pg_t;

endpackage

// File: rtl/cla_block.sv
// One BLOCK-bit carry-lookahead block: purely combinational a + b + c_in.
module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] sum,
    output logic             c_out
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = c_in;

    // Carry chain expressed as generate/propagate recurrence per bit
    for (genvar gi = 0; gi < BLOCK; gi++) begin : g_carry
        assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
    end

    assign sum   = p ^ c[BLOCK-1:0];
    assign c_out = c[BLOCK];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves BLOCK*BLK_PER_STAGE sum bits and forwards its carry;
// operand bits not yet consumed travel alongside, shrinking stage by stage.
// Optional feature: define CLA_PIPE_OVF_EN to compute the signed overflow flag.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int BLOCK         = CLA_BLOCK,
    parameter int BLK_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S    = BLOCK * BLK_PER_STAGE;
    localparam int NSTG = WIDTH / S;

    if ((S == 0) || ((WIDTH % S) != 0) || (NSTG < 1)) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK*BLK_PER_STAGE");
    end

    // Single global advance: the whole pipe moves only when the output slot frees
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
        localparam int IW = WIDTH - gi * S;

        logic [IW-1:0]         a_st;
        logic [IW-1:0]         b_st;
        logic                  c_st;
        logic                  v_st;
        logic [BLK_PER_STAGE:0] cch;
        logic [S-1:0]          s_slice;
        logic [(gi+1)*S-1:0]   sum_next;
        logic [(gi+1)*S-1:0]   sum_reg;
        logic                  c_reg;
        logic                  v_reg;

        if (gi == 0) begin : g_src
            // Subtract folds into add: invert b and force the carry-in
            assign a_st     = a;
            assign b_st     = b ^ {WIDTH{sub}};
            assign c_st     = sub | cin;
            assign v_st     = in_valid;
            assign sum_next = s_slice;
        end else begin : g_src
            assign a_st     = g_stg[gi-1].g_rem.a_rem_reg;
            assign b_st     = g_stg[gi-1].g_rem.b_rem_reg;
            assign c_st     = g_stg[gi-1].c_reg;
            assign v_st     = g_stg[gi-1].v_reg;
            assign sum_next = {s_slice, g_stg[gi-1].sum_reg};
        end

        assign cch[0] = c_st;

        for (genvar gb = 0; gb < BLK_PER_STAGE; gb++) begin : g_blk
            cla_block #(.BLOCK(BLOCK)) u_blk (
                .a     (a_st[gb*BLOCK +: BLOCK]),
                .b     (b_st[gb*BLOCK +: BLOCK]),
                .c_in  (cch[gb]),
                .sum   (s_slice[gb*BLOCK +: BLOCK]),
                .c_out (cch[gb+1])
            );
        end

        // Stage result: valid flag, stage carry-out and accumulated sum bits
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_reg   <= 1'b0;
                c_reg   <= 1'b0;
                sum_reg <= '0;
            end else if (adv) begin
                v_reg   <= v_st;
                c_reg   <= cch[BLK_PER_STAGE];
                sum_reg <= sum_next;
            end
        end

        if (gi < NSTG - 1) begin : g_rem
            logic [IW-S-1:0] a_rem_reg;
            logic [IW-S-1:0] b_rem_reg;

            // Skew-delay the operand bits that later stages still need
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_reg <= '0;
                    b_rem_reg <= '0;
                end else if (adv) begin
                    a_rem_reg <= a_st[IW-1:S];
                    b_rem_reg <= b_st[IW-1:S];
                end
            end
        end
    end

    assign out_valid = g_stg[NSTG-1].v_reg;
    assign sum       = g_stg[NSTG-1].sum_reg;
    assign cout      = g_stg[NSTG-1].c_reg;

`ifdef CLA_PIPE_OVF_EN
    logic ovf_next;
    logic ovf_reg;

    // Carry into the MSB recovered from p ^ sum at the top bit, XOR carry-out
    assign ovf_next = g_stg[NSTG-1].a_st[S-1] ^ g_stg[NSTG-1].b_st[S-1]
                    ^ g_stg[NSTG-1].s_slice[S-1] ^ g_stg[NSTG-1].cch[BLK_PER_STAGE];

    // Overflow flag travels with the final stage result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (adv) begin
            ovf_reg <= ovf_next;
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule
